sprite_blit_ctrl: RTL and testbench
===================================

// Module: sprite_blit_ctrl
// PURPOSE
// Sequences one 8x8 sprite draw: walks pixel index 0..63 and reads colours from the sprite ROM.
// Computes each framebuffer address as a 640-wide, 19-bit linear address that grows upward from the anchor.
// Writes non-transparent pixels to the framebuffer port under a ready/valid handshake.
// Sits between the game-logic draw requester and the framebuffer write arbiter.
// PARAMETERS
// TRANSPARENT  8'hE3  colour code that is never written (pixel skipped)
// SCREEN_W     640    framebuffer line pitch in pixels
// PORTS
// clk          in   1   system clock
// rst          in   1   asynchronous, active-high reset
// draw_req     in   1   draw request; held by requester until draw_ack
// draw_coord   in   19  anchor address (bottom-left pixel, row 0 col 0)
// draw_sprite  in   4   sprite id
// draw_ack     out  1   1-cycle pulse: request accepted, inputs latched
// busy         out  1   high from cycle after ack until draw finishes
// done         out  1   1-cycle pulse after last pixel slot retires
// rom_en       out  1   sprite ROM read enable (ROM output holds when 0)
// rom_addr     out  10  {sprite_id, idx[5:0]}
// rom_data     in   8   colour; synchronous ROM, valid 1 cycle after rom_en&rom_addr
// fb_we        out  1   framebuffer write valid (registered)
// fb_addr      out  19  framebuffer write address (registered)
// fb_data      out  8   framebuffer write colour (registered)
// fb_ready     in   1   write accepted when fb_we&fb_ready at clk edge
// BEHAVIOUR
// - Clock: clk. Reset: rst, asynchronous, active-high.
// - Reset: state IDLE; idx=0; draw_ack, busy, done, rom_en, fb_we = 0; fb_addr, fb_data, rom_addr = 0.
// - States and transitions:
//   - IDLE: when draw_req=1, pulse draw_ack, latch coord/sprite, go to RUN.
//   - RUN: issue reads and drain the pipeline.
//   - FLUSH: wait for the last write to be accepted.
//   - DONE: pulse done for 1 cycle, then return to IDLE.
// - draw_req while not IDLE: ignored, no ack.
// - Pipeline stage S1: rom_en=1, rom_addr={id,idx}, idx++ per cycle.
// - Pipeline stage S2: rom_data is valid for S1's idx.
// - Output register: at the end of S2, load fb_addr/fb_data. Set fb_we=1 unless the pixel is transparent or clipped.
// - Stall = fb_we & ~fb_ready.
//   - On stall, freeze idx and S2 valid/idx, drive rom_en=0, and hold fb_* unchanged.
//   - No pixel is dropped or duplicated.
// - Address: r=idx[5:3], c=idx[2:0]; fb_addr = coord - SCREEN_W*r + c, computed mod 2^19.
// - Vertical clip: pixel suppressed (fb_we=0, slot still consumed) if coord < SCREEN_W*r.
// - No horizontal clip: c overflow past the line end wraps into the next line.
// - Transparent or clipped slots are bubbles: they consume a cycle but assert no fb_we.
// - Latency with no stalls: ack cycle 0; first S1 cycle 1; first fb_we visible cycle 3.
// - Write k is visible on cycle 3+k; done pulses on cycle 67 with busy=0 that cycle.
// - Each stall cycle delays done by one cycle.
// - busy=1 from cycle 1 until the cycle before done.
// - Reset mid-draw: aborts immediately; no done pulse; fb_we low asynchronously.
// STRUCTURE
// - Shared include sprite_defs.vh holds:
//   - SCREEN_W, FB_AW=19, SPRITE_DIM=8, ROM_AW=10, COLOR_W=8, TRANSPARENT.
//   - State encodings IDLE/RUN/FLUSH/DONE.
// - One sub-module, sprite_pixel_addr (combinational), computes {coord, idx} -> {fb_addr, clipped}.
// - FSM, idx counter and the stall/pipeline registers stay in this module.
// TESTING
// - Reset mid-draw: assert rst at write 10 -> fb_we=0, busy=0, no done; the next request draws all 64 pixels.
// - Opaque draw, coord=64200, fb_ready=1:
//   - 64 writes on cycles 3..66; write 0 addr 64200, write 8 addr 63560, write 63 addr 59727.
//   - fb_data matches rom[{id,idx}]; done on cycle 67.
// - Transparent: sprite all 8'hE3 except idx 9 -> exactly one write (addr 63561); done still on cycle 67.
// - Backpressure: hold fb_ready=0 for 5 cycles while write 3 is pending:
//   - fb_addr/fb_data stay stable; all 64 writes are in order with no duplicates; done on cycle 72.
// - Clip: coord=1000 -> 16 writes (rows 0-1 only, addr 1000..1007 and 360..367); rows 2-7 suppressed; done on cycle 67.
// - Request while busy: second draw_req during RUN gets no ack; it is acked the cycle after done, then draws normally.

Source files
------------

// File: rtl/sprite_blit_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sprite_blit_ctrl_pkg
// Shared constants and types for the sprite blitter:
//   - framebuffer geometry (640-pixel pitch, 19-bit linear address)
//   - sprite geometry (8x8, 6-bit pixel index) and ROM addressing
//   - transparent colour code
//   - controller state encoding
// ----------------------------------------------------------------------------
package sprite_blit_ctrl_pkg;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned FB_AW      = 19;
    localparam int unsigned SPRITE_DIM = 8;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned ROM_AW     = ID_W + IDX_W;
    localparam int unsigned COLOR_W    = 8;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 8'hE3;
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(SPRITE_DIM * SPRITE_DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_pixel_addr.sv
// ----------------------------------------------------------------------------
// sprite_pixel_addr
// Maps a sprite pixel index onto the framebuffer. Row r = idx[5:3] grows
// upward from the anchor (one pitch lower in linear address per row),
// column c = idx[2:0] grows rightward with no horizontal clip.
// Ports:
//   coord    in   anchor address (bottom-left pixel)
//   idx      in   pixel index 0..63
//   fb_addr  out  coord - SCREEN_W*r + c, modulo 2^19
//   clipped  out  row lies above the top of the framebuffer
// ----------------------------------------------------------------------------
module sprite_pixel_addr
    import sprite_blit_ctrl_pkg::*;
(
    input  logic [FB_AW-1:0] coord,
    input  logic [IDX_W-1:0] idx,
    output logic [FB_AW-1:0] fb_addr,
    output logic             clipped
);

    logic [FB_AW-1:0] row_off;

    // Largest offset is 7*640 = 4480, so the 19-bit truncation never loses bits.
    assign row_off = FB_AW'(SCREEN_W * 32'(idx[5:3]));
    assign fb_addr = coord - row_off + FB_AW'(idx[2:0]);
    assign clipped = (coord < row_off);

endmodule

// File: rtl/sprite_blit_ctrl.sv
// ----------------------------------------------------------------------------
// sprite_blit_ctrl
// Draws one 8x8 sprite: issues ROM reads for pixel 0..63 (stage S1), pairs
// the returned colour with its index (stage S2), and presents registered
// framebuffer writes under a ready/valid handshake. Transparent or clipped
// pixels become bubbles. A stalled write freezes the whole pipeline.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   draw_req/draw_ack     request (held until ack) / 1-cycle accept pulse
//   draw_coord/sprite     anchor address / sprite id, latched on accept
//   busy, done            draw in progress / 1-cycle completion pulse
//   rom_en/addr/data      synchronous sprite ROM (data 1 cycle after en)
//   fb_we/addr/data       registered framebuffer write, held while stalled
//   fb_ready              framebuffer accepts the write at this edge
// ----------------------------------------------------------------------------
module sprite_blit_ctrl
    import sprite_blit_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               draw_req,
    input  logic [FB_AW-1:0]   draw_coord,
    input  logic [ID_W-1:0]    draw_sprite,
    output logic               draw_ack,
    output logic               busy,
    output logic               done,
    output logic               rom_en,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ready
);

    state_t            state;
    logic [FB_AW-1:0]  coord_q;
    logic [ID_W-1:0]   sprite_q;
    logic [IDX_W-1:0]  idx;
    logic              s1_valid;
    logic              s2_valid;
    logic [IDX_W-1:0]  s2_idx;
    logic              stall;
    logic [FB_AW-1:0]  pix_addr;
    logic              pix_clipped;

    assign stall = fb_we & ~fb_ready;

    // The ROM must not advance while stalled, otherwise the colour sitting
    // in S2 would be overwritten; gating the enable keeps rom_data frozen.
    assign rom_en = s1_valid & ~stall;

    sprite_pixel_addr u_pixel_addr (
        .coord   (coord_q),
        .idx     (s2_idx),
        .fb_addr (pix_addr),
        .clipped (pix_clipped)
    );

    // NOTE: all state here is updated with <= so each register sees the
    // pre-edge value of every other register, which is what makes the
    // S1 -> S2 -> output shift behave as a pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            coord_q  <= '0;
            sprite_q <= '0;
            idx      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            rom_addr <= '0;
            draw_ack <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            draw_ack <= 1'b0;
            done     <= 1'b0;
            case (state)
                // DONE behaves like IDLE so a request held through the
                // previous draw is accepted on the cycle after done.
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (draw_req) begin
                        draw_ack <= 1'b1;
                        coord_q  <= draw_coord;
                        sprite_q <= draw_sprite;
                        idx      <= '0;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN, FLUSH: begin
                    if (state == RUN) begin
                        busy <= 1'b1;
                    end
                    if (!stall) begin
                        s2_valid <= s1_valid;
                        s2_idx   <= rom_addr[IDX_W-1:0];
                        if (s2_valid) begin
                            fb_we   <= (rom_data != TRANSPARENT) && !pix_clipped;
                            fb_addr <= pix_addr;
                            fb_data <= rom_data;
                        end else begin
                            fb_we <= 1'b0;
                        end
                        if (state == RUN) begin
                            s1_valid <= 1'b1;
                            rom_addr <= {sprite_q, idx};
                            idx      <= idx + 1'b1;
                            if (idx == IDX_LAST) begin
                                state <= FLUSH;
                            end
                        end else begin
                            s1_valid <= 1'b0;
                            // Pipeline empty and the final output slot is
                            // retiring at this edge.
                            if (!s1_valid && !s2_valid) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
module tb_sprite_blit_ctrl;

    logic        clk;
    logic        rst;
    logic        draw_req;
    logic [18:0] draw_coord;
    logic [3:0]  draw_sprite;
    logic        draw_ack;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ready;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  rom [0:1023];

    int          checks = 0;
    int          failures = 0;
    int          tcyc = 0;
    int          ack_t = 0;
    int          wr_cnt = 0;
    int          first_wr_rel = -1;
    logic [18:0] wr_addr [0:63];
    bit          hold_valid = 0;
    logic [18:0] hold_addr;
    logic [7:0]  hold_data;

    sprite_blit_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .draw_req    (draw_req),
        .draw_coord  (draw_coord),
        .draw_sprite (draw_sprite),
        .draw_ack    (draw_ack),
        .busy        (busy),
        .done        (done),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_ready    (fb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tcyc++;

    // Synchronous sprite ROM model.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected writes for one draw, derived from the ROM contents and the
    // addressing / clipping / transparency rules.
    task automatic push_expected(input logic [18:0] coord, input logic [3:0] id);
        int   r;
        int   c;
        logic [7:0] d;
        wr_t  e;
        for (int i = 0; i < 64; i++) begin
            r = i / 8;
            c = i % 8;
            d = rom[{id, 6'(i)}];
            if (int'(coord) >= 640 * r && d != 8'hE3) begin
                e.addr = 19'(int'(coord) - 640 * r + c);
                e.data = d;
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the
    // active edge.
    always @(negedge clk) begin
        wr_t e;
        if (draw_ack) begin
            ack_t  = tcyc;
            wr_cnt = 0;
        end
        if (fb_we) begin
            if (hold_valid) begin
                check("stall_hold_addr", 32'(fb_addr), 32'(hold_addr));
                check("stall_hold_data", 32'(fb_data), 32'(hold_data));
            end
            if (fb_ready) begin
                hold_valid = 0;
                check("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e.addr));
                    check("wr_data", 32'(fb_data), 32'(e.data));
                end
                if (wr_cnt == 0) first_wr_rel = tcyc - ack_t;
                if (wr_cnt < 64) wr_addr[wr_cnt] = fb_addr;
                wr_cnt++;
            end else begin
                hold_valid = 1;
                hold_addr  = fb_addr;
                hold_data  = fb_data;
            end
        end else begin
            hold_valid = 0;
        end
    end

    task automatic raise_req(input logic [18:0] coord, input logic [3:0] id);
        @(posedge clk);
        #1;
        draw_req    = 1'b1;
        draw_coord  = coord;
        draw_sprite = id;
        push_expected(coord, id);
    endtask

    // Returns one time unit after the edge that starts cycle 1.
    task automatic wait_ack(input string tag);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (draw_ack) begin
                got = 1;
                break;
            end
        end
        check({tag, "_ack"}, 32'(got), 1);
        @(posedge clk);
        #1;
        draw_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        bit got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 1);
        check({tag, "_done_cycle"}, 32'(tcyc - ack_t), 32'(exp_cyc));
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int early_acks;
        int done_t;
        int done_cnt;

        rst         = 1'b1;
        draw_req    = 1'b0;
        draw_coord  = '0;
        draw_sprite = '0;
        fb_ready    = 1'b1;
        // Sprite 2: transparent except pixel 9; others: distinct opaque colours.
        for (int i = 0; i < 1024; i++) begin
            if (i / 64 == 2) rom[i] = (i % 64 == 9) ? 8'h55 : 8'hE3;
            else             rom[i] = 8'((i / 64) * 16 + (i % 64));
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_draw_ack", 32'(draw_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rom_en", 32'(rom_en), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        rst = 1'b0;

        // Opaque draw.
        raise_req(19'd64200, 4'd1);
        wait_ack("opaque");
        check("opaque_busy_c1", 32'(busy), 1);
        check("opaque_rom_en_c1", 32'(rom_en), 1);
        check("opaque_rom_addr_c1", 32'(rom_addr), 64);
        wait_done("opaque", 67);
        check("opaque_first_wr_cycle", 32'(first_wr_rel), 3);
        check("opaque_wr_count", 32'(wr_cnt), 64);
        check("opaque_wr0_addr", 32'(wr_addr[0]), 64200);
        check("opaque_wr8_addr", 32'(wr_addr[8]), 63560);
        check("opaque_wr63_addr", 32'(wr_addr[63]), 59727);

        // Transparent sprite: single write at idx 9.
        raise_req(19'd64200, 4'd2);
        wait_ack("transp");
        wait_done("transp", 67);
        check("transp_wr_count", 32'(wr_cnt), 1);
        check("transp_wr_addr", 32'(wr_addr[0]), 63561);
        check("transp_first_wr_cycle", 32'(first_wr_rel), 12);

        // Backpressure: 5 stall cycles on write 3.
        raise_req(19'd64200, 4'd4);
        wait_ack("bp");
        repeat (5) @(posedge clk);
        #1;
        fb_ready = 1'b0;
        check("bp_pending_we", 32'(fb_we), 1);
        check("bp_pending_addr", 32'(fb_addr), 64203);
        repeat (5) @(posedge clk);
        #1;
        fb_ready = 1'b1;
        wait_done("bp", 72);
        check("bp_wr_count", 32'(wr_cnt), 64);

        // Vertical clip: only rows 0 and 1 land.
        raise_req(19'd1000, 4'd3);
        wait_ack("clip");
        wait_done("clip", 67);
        check("clip_wr_count", 32'(wr_cnt), 16);
        check("clip_wr0_addr", 32'(wr_addr[0]), 1000);
        check("clip_wr7_addr", 32'(wr_addr[7]), 1007);
        check("clip_wr8_addr", 32'(wr_addr[8]), 360);
        check("clip_wr15_addr", 32'(wr_addr[15]), 367);

        // Request while busy: held until the cycle after done.
        raise_req(19'd64200, 4'd1);
        wait_ack("busy1");
        repeat (20) @(posedge clk);
        #1;
        draw_req    = 1'b1;
        draw_coord  = 19'd5000;
        draw_sprite = 4'd3;
        push_expected(19'd5000, 4'd3);
        early_acks = 0;
        done_t     = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (draw_ack) early_acks++;
            if (done) begin
                done_t = tcyc;
                break;
            end
        end
        check("busy_no_early_ack", 32'(early_acks), 0);
        check("busy1_done_cycle", 32'(done_t - ack_t), 67);
        @(negedge clk);
        check("busy2_ack_after_done", 32'(draw_ack), 1);
        check("busy2_ack_cycle", 32'(tcyc - done_t), 1);
        @(posedge clk);
        #1;
        draw_req = 1'b0;
        wait_done("busy2", 67);
        check("busy2_wr_count", 32'(wr_cnt), 64);

        // Reset mid-draw at write 10.
        raise_req(19'd64200, 4'd1);
        wait_ack("midrst");
        repeat (12) @(posedge clk);
        #1;
        check("midrst_pre_we", 32'(fb_we), 1);
        check("midrst_pre_addr", 32'(fb_addr), 63562);
        rst = 1'b1;
        #1;
        check("midrst_fb_we", 32'(fb_we), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rom_en", 32'(rom_en), 0);
        exp_q.delete();
        hold_valid = 0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 0);
        raise_req(19'd64200, 4'd4);
        wait_ack("postrst");
        wait_done("postrst", 67);
        check("postrst_wr_count", 32'(wr_cnt), 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
